// File: rtl/feature_lut_arbiter_pkg.sv
// Shared constants and helpers for the feature LUT arbiter slice.
// Provides the LUT width defaults, the stats counter width and the requester-id width helper.
package feature_lut_arbiter_pkg;

  localparam int LUT_ADDR_WIDTH = 14;
  localparam int LUT_DATA_WIDTH = 32;
  localparam int STAT_WIDTH     = 16;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/feature_lut_arbiter_if.sv
// Request, ROM and response signals of the feature LUT arbiter.
// The master modport is the requester/ROM/consumer side; slave is the arbiter.
interface feature_lut_arbiter_if
  import feature_lut_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
);
  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_data;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDW-1:0]                rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_addr, rom_data, rsp_ready,
    input  req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rom_data, rsp_ready,
    output req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/feature_lut_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins.
// Produces a one-hot grant plus its index; all-zero grant when en is low.
module feature_lut_arbiter_rr_arbiter
  import feature_lut_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic                            en,
  input  logic [id_width(NUM_REQ)-1:0]    ptr,
  output logic [NUM_REQ-1:0]              grant,
  output logic [id_width(NUM_REQ)-1:0]    idx
);
  localparam int IDW = id_width(NUM_REQ);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && en && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/feature_lut_arbiter.sv
// Shares one registered-read LUT ROM among NUM_REQ requesters with credit-limited response FIFO.
// Optional FEATURE_LUT_ARB_STATS_EN adds saturating grant/stall counters.
module feature_lut_arbiter
  import feature_lut_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = LUT_DATA_WIDTH,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  feature_lut_arbiter_if.slave           bus
`ifdef FEATURE_LUT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0]  stat_grants,
  output logic [STAT_WIDTH-1:0]          stat_stall
`endif
);
  localparam int IDW = id_width(NUM_REQ);
  localparam int PW  = $clog2(RSP_FIFO_DEPTH);
  localparam int CW  = PW + 2;

  logic [IDW-1:0]        ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        gnt_idx;
  logic                  credit_ok;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;

  logic                  vld_p0, vld_p1;
  logic [IDW-1:0]        id_p0, id_p1;

  logic [IDW-1:0]        id_mem   [RSP_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [RSP_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  push, pop;

  // Every accepted read owns a FIFO slot until popped, so the FIFO cannot overflow.
  assign credit_ok = (CW'(vld_p0) + CW'(vld_p1) + CW'(count)) < CW'(RSP_FIFO_DEPTH);

  feature_lut_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (bus.req_valid),
    .en    (credit_ok & ~rst),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel_addr = sel_addr | bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Stage p0: accepted address drives the ROM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      bus.rom_addr <= '0;
      vld_p0       <= 1'b0;
      id_p0        <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        id_p0        <= gnt_idx;
        bus.rom_addr <= sel_addr;
        ptr          <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  // Stage p1: tag aligned with the ROM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
    end
  end

  assign push = vld_p1;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]   <= id_p1;
      data_mem[wr_ptr] <= bus.rom_data;
    end
  end

  // Head is forced to zero while empty so reset leaves clean outputs.
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? id_mem[rd_ptr]   : '0;
  assign bus.rsp_data  = bus.rsp_valid ? data_mem[rd_ptr] : '0;

`ifdef FEATURE_LUT_ARB_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

  logic [STAT_WIDTH-1:0] grant_cnt [NUM_REQ];
  logic [STAT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      if (|bus.req_valid && !credit_ok) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*STAT_WIDTH +: STAT_WIDTH] = grant_cnt[i];
  end
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_feature_lut_arbiter.sv
// Bench for feature_lut_arbiter: directed steps plus random traffic against a queue-based model.
// Model view: an accept reserves a slot until popped; its word becomes visible 2 edges later.
module tb_feature_lut_arbiter;
  import feature_lut_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int D  = 4;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          t;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  feature_lut_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef FEATURE_LUT_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stall;
`endif

  feature_lut_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_FIFO_DEPTH(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FEATURE_LUT_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stall  (stat_stall)
`endif
  );

  function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Registered-read ROM
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int outstanding = 0;
  int mptr = 0;
  int mg [N];
  int mstall = 0;
  rsp_t rq [$];
  logic [N*AW-1:0] addrs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < N; i++) addrs[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic model_reset();
    rq.delete();
    outstanding = 0;
    mptr = 0;
    mstall = 0;
    for (int i = 0; i < N; i++) mg[i] = 0;
  endtask

  task automatic check_stats();
`ifdef FEATURE_LUT_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(mg[i]));
    chk("stat_stall", 64'(stat_stall), 64'(mstall));
`endif
  endtask

  // One clock: drive at posedge+1, check at negedge, update model at next posedge.
  task automatic cycle(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] eg;
    int gid;
    logic ev;
    logic pp;
    bus.req_valid = v;
    bus.req_addr  = addrs;
    bus.rsp_ready = rr;
    @(negedge clk);
    eg  = '0;
    gid = -1;
    if (outstanding < D) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr + k) % N;
        if (gid < 0 && v[c]) begin
          gid   = c;
          eg[c] = 1'b1;
        end
      end
    end
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    ev = (rq.size() > 0) && (rq[0].t <= cyc);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(rq[0].id));
      chk("rsp_data", 64'(bus.rsp_data), 64'(rq[0].data));
    end
    check_stats();
    pp = ev && rr;
    if (|v && outstanding >= D && mstall < 65535) mstall++;
    @(posedge clk);
    cyc++;
    if (pp) begin
      void'(rq.pop_front());
      outstanding--;
    end
    if (gid >= 0) begin
      rq.push_back('{gid, rom_fn(addrs[gid*AW +: AW]), cyc + 2});
      outstanding++;
      mptr = (gid + 1) % N;
      if (mg[gid] < 65535) mg[gid]++;
    end
    #1;
  endtask

  initial begin
    model_reset();
    addrs         = '0;
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    check_stats();
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request at address 5
    addrs[AW-1:0] = AW'(5);
    cycle(4'b0001, 1'b1);
    chk("t1_rom_addr", 64'(bus.rom_addr), 64'(5));
    repeat (4) cycle(4'b0000, 1'b1);

    // All requesters held: round-robin, one per cycle
    for (int i = 0; i < 12; i++) begin
      rand_addrs();
      cycle(4'b1111, 1'b1);
    end
    repeat (4) cycle(4'b0000, 1'b1);

    // Back-pressure: four accepts then stall, then drain in order
    for (int i = 0; i < 8; i++) begin
      rand_addrs();
      cycle(4'b0010, 1'b0);
    end
    repeat (8) cycle(4'b0000, 1'b1);

    // Full FIFO with a single-cycle pop
    for (int i = 0; i < 6; i++) begin
      rand_addrs();
      cycle(4'b0010, 1'b0);
    end
    rand_addrs();
    cycle(4'b0010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rand_addrs();
      cycle(4'b0010, 1'b0);
    end
    repeat (8) cycle(4'b0000, 1'b1);

    // Reset with two reads in flight
    for (int i = 0; i < 3; i++) begin
      rand_addrs();
      cycle(4'b1111, 1'b0);
    end
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_req_ready", 64'(bus.req_ready), 64'(0));
    chk("t5_rom_addr", 64'(bus.rom_addr), 64'(0));
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("t5_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("t5_rsp_data", 64'(bus.rsp_data), 64'(0));
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    repeat (5) cycle(4'b0000, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_addrs();
      cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    repeat (8) cycle(4'b0000, 1'b1);

`ifdef FEATURE_LUT_ARB_STATS_EN
    // Saturate requester 2's grant counter, then create credit stalls
    for (int i = 0; i < 70000; i++) begin
      addrs[2*AW +: AW] = AW'(i);
      cycle(4'b0100, 1'b1);
    end
    repeat (8) cycle(4'b0100, 1'b0);
    chk("t6_grants2_sat", 64'(stat_grants[2*16 +: 16]), 64'(16'hFFFF));
    repeat (8) cycle(4'b0000, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait never completes
  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
